// File: rtl/spi_master.sv
// Z80-port SPI initiator (divMMC style): one full-duplex mode-0 byte per transfer, MSB first.
// Optional read-triggered transfers (divMMC read-ahead) are enabled by defining SPI_RDTRIG_EN.
module spi_master #(
    parameter int unsigned DIV = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       csWr,
    input  logic       dataWr,
    input  logic       dataRd,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       busy,
    output logic       cs,
    output logic       ck,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] divcnt_q, divcnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      q_q, q_d;
    logic            cs_q, cs_d;
    logic            ck_q, ck_d;
    logic            mosi_q, mosi_d;

    logic            start_rd;
    logic            start;
    logic [7:0]      load_byte;
    logic            half_end;

`ifdef SPI_RDTRIG_EN
    // Read-ahead: a CPU read in idle clocks out 8'hFF; a simultaneous write takes priority.
    assign start_rd = dataRd & ~dataWr;
`else
    logic unused_rd;
    assign unused_rd = dataRd;
    assign start_rd  = 1'b0;
`endif

    assign start     = (state_q == StIdle) & (dataWr | start_rd);
    assign load_byte = dataWr ? d : 8'hFF;
    assign half_end  = ce & (divcnt_q == CntW'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        divcnt_d = divcnt_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        q_d      = q_q;
        cs_d     = cs_q;
        ck_d     = ck_q;
        mosi_d   = mosi_q;

        if (csWr) begin
            cs_d = d[0];
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tx_d     = load_byte;
                    mosi_d   = load_byte[7];
                    rx_d     = 8'h00;
                    divcnt_d = '0;
                    bit_d    = 3'd0;
                    ck_d     = 1'b0;
                    state_d  = StLo;
                end
            end
            StLo: begin
                if (half_end) begin
                    divcnt_d = '0;
                    ck_d     = 1'b1;
                    rx_d     = {rx_q[6:0], miso};
                    state_d  = StHi;
                end else if (ce) begin
                    divcnt_d = divcnt_q + CntW'(1);
                end
            end
            StHi: begin
                if (half_end) begin
                    divcnt_d = '0;
                    ck_d     = 1'b0;
                    if (bit_q == 3'd7) begin
                        q_d     = rx_q;
                        mosi_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                        bit_d   = bit_q + 3'd1;
                        state_d = StLo;
                    end
                end else if (ce) begin
                    divcnt_d = divcnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            divcnt_q <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
            q_q      <= 8'hFF;
            cs_q     <= 1'b1;
            ck_q     <= 1'b0;
            mosi_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            divcnt_q <= divcnt_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            q_q      <= q_d;
            cs_q     <= cs_d;
            ck_q     <= ck_d;
            mosi_q   <= mosi_d;
        end
    end

    assign q    = q_q;
    assign busy = (state_q != StIdle);
    assign cs   = cs_q;
    assign ck   = ck_q;
    assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (DIV=1): a byte-level SPI responder model plus a scoreboard
// of expected received/transmitted bytes, checked with immediate assertions.
module tb_spi_master;

    localparam int unsigned DIV = 1;

    logic       clock;
    logic       reset;
    logic       ce;
    logic       csWr;
    logic       dataWr;
    logic       dataRd;
    logic [7:0] d;
    logic [7:0] q;
    logic       busy;
    logic       cs;
    logic       ck;
    logic       mosi;
    logic       miso;

    spi_master #(.DIV(DIV)) dut (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .csWr   (csWr),
        .dataWr (dataWr),
        .dataRd (dataRd),
        .d      (d),
        .q      (q),
        .busy   (busy),
        .cs     (cs),
        .ck     (ck),
        .mosi   (mosi),
        .miso   (miso)
    );

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [7:0] slave_sr  = 8'hFF;
    logic [7:0] mosi_cap  = 8'h00;
    int         ck_rises  = 0;
    int         busy_cyc  = 0;
    int         ce_cnt    = 0;
    logic       ce_rand   = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Responder shifts its next bit out on each falling SCK edge (mode 0).
    assign miso = slave_sr[7];
    always @(negedge ck) slave_sr = {slave_sr[6:0], 1'b1};

    always @(posedge ck) begin
        mosi_cap = {mosi_cap[6:0], mosi};
        ck_rises++;
    end

    // ce changes just after the active edge; the negedge monitor sees the value for the next edge.
    always @(posedge clock) begin
        #1;
        ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clock) begin
        if (busy === 1'b1) begin
            busy_cyc++;
            if (ce === 1'b1) ce_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] data, input logic [7:0] slv, input logic wr,
                          input logic rd, input logic csw, input logic [7:0] exp_tx);
        exp_t e;
        @(negedge clock);
        slave_sr = slv;
        mosi_cap = 8'h00;
        ck_rises = 0;
        busy_cyc = 0;
        ce_cnt   = 0;
        d        = data;
        dataWr   = wr;
        dataRd   = rd;
        csWr     = csw;
        e.rx     = slv;
        e.tx     = exp_tx;
        sb.push_back(e);
        @(negedge clock);
        dataWr = 1'b0;
        dataRd = 1'b0;
        csWr   = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic finish_xfer(input string tag, input int exp_ce);
        exp_t e;
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_done"}, busy, 0);
        if (sb.size() == 0) begin
            $display("FAIL %s_scoreboard: observed=empty expected=entry", tag);
            $fatal(1, "scoreboard underflow");
        end
        e = sb.pop_front();
        chk({tag, "_q"}, q, e.rx);
        chk({tag, "_mosi"}, mosi_cap, e.tx);
        chk({tag, "_ckpulses"}, ck_rises, 8);
        chk({tag, "_ce"}, ce_cnt, exp_ce);
        chk({tag, "_mosi_idle"}, mosi, 1);
        chk({tag, "_ck_idle"}, ck, 0);
    endtask

    task automatic wait_rises(input string tag, input int k);
        int n = 0;
        while (ck_rises < k && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_reach"}, (ck_rises >= k), 1);
    endtask

    initial begin
        exp_t drop;
        reset  = 1'b0;
        ce     = 1'b1;
        csWr   = 1'b0;
        dataWr = 1'b0;
        dataRd = 1'b0;
        d      = 8'h00;

        // 1: reset state, held while reset is asserted despite strobes
        @(negedge clock);
        d      = 8'h00;
        dataWr = 1'b1;
        csWr   = 1'b1;
        repeat (3) @(negedge clock);
        dataWr = 1'b0;
        csWr   = 1'b0;
        chk("rst_cs", cs, 1);
        chk("rst_ck", ck, 0);
        chk("rst_mosi", mosi, 1);
        chk("rst_q", q, 8'hFF);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_busy", busy, 0);

        // 2: basic byte, A5 out, 3C in
        launch(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5);
        chk("t2_mosi_first", mosi, 1);
        finish_xfer("t2", 16 * DIV);
        chk("t2_busy_cycles", busy_cyc, 16 * DIV);

        // 3: write while busy is ignored
        launch(8'hA5, 8'hC3, 1'b1, 1'b0, 1'b0, 8'hA5);
        wait_rises("t3", 3);
        d      = 8'h00;
        dataWr = 1'b1;
        @(negedge clock);
        dataWr = 1'b0;
        chk("t3_q_stable", q, 8'h3C);
        finish_xfer("t3", 16 * DIV);

        // 4: chip select, including a change mid-transfer
        d    = 8'h00;
        csWr = 1'b1;
        @(negedge clock);
        csWr = 1'b0;
        chk("t4_cs_low", cs, 0);
        launch(8'h3C, 8'h0F, 1'b1, 1'b0, 1'b0, 8'h3C);
        wait_rises("t4", 2);
        d    = 8'h01;
        csWr = 1'b1;
        @(negedge clock);
        csWr = 1'b0;
        chk("t4_cs_high", cs, 1);
        chk("t4_still_busy", busy, 1);
        finish_xfer("t4", 16 * DIV);

        // 6: reset mid-transfer aborts; a fresh transfer then completes
        launch(8'hE7, 8'h81, 1'b1, 1'b0, 1'b0, 8'hE7);
        wait_rises("t6", 4);
        reset = 1'b0;
        #1;
        chk("t6_cs", cs, 1);
        chk("t6_ck", ck, 0);
        chk("t6_busy", busy, 0);
        chk("t6_q", q, 8'hFF);
        chk("t6_mosi", mosi, 1);
        drop = sb.pop_front();
        @(negedge clock);
        reset = 1'b1;
        launch(8'h5A, 8'h66, 1'b1, 1'b0, 1'b0, 8'h5A);
        finish_xfer("t6b", 16 * DIV);

        // csWr and dataWr together: both act
        launch(8'h96, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h96);
        chk("both_cs", cs, 0);
        finish_xfer("both", 16 * DIV);

`ifdef SPI_RDTRIG_EN
        // 5: read-ahead with a gated ce; the read returns the previous byte
        chk("t5_read_value", q, 8'h3C);
        ce_rand = 1'b1;
        launch(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF);
        chk("t5_q_hold", q, 8'h3C);
        finish_xfer("t5", 16 * DIV);
        ce_rand = 1'b0;
        // write wins over a simultaneous read
        launch(8'h81, 8'h42, 1'b1, 1'b1, 1'b0, 8'h81);
        finish_xfer("t5w", 16 * DIV);
`else
        // without read-ahead, dataRd alone neither starts a transfer nor touches q
        @(negedge clock);
        dataRd = 1'b1;
        @(negedge clock);
        dataRd = 1'b0;
        chk("rd_ignored_busy", busy, 0);
        chk("rd_ignored_q", q, 8'h3C);
        ce_rand = 1'b1;
        launch(8'hC9, 8'h17, 1'b1, 1'b0, 1'b0, 8'hC9);
        finish_xfer("gated", 16 * DIV);
        ce_rand = 1'b0;
`endif

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
